// File: rtl/lpc_reg_pkg.sv
// Shared types and defaults for the LPC register-file access arbiter.
// The defaults are used by lpc_reg_arbiter when no parameter override is given.
package lpc_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } lpc_arb_state_t;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_AUX  = 1'b1
    } lpc_req_id_t;

    localparam logic [7:0]  LPC_REG_ADDR_MAX = 8'h1F;
    localparam logic [7:0]  LPC_OOR_RDATA    = 8'hFF;
    localparam int unsigned LPC_STARVE_LIMIT = 4;

    // Counter never wraps: it sticks at its all-ones value.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/lpc_reg_arbiter.sv
// Two-requester (Host priority, Aux starvation-protected) arbiter for the
// single-port LPC register file bus; one strobe per transaction, 4 cycles each.
module lpc_reg_arbiter
    import lpc_reg_pkg::*;
#(
    parameter logic [7:0]  ADDR_MAX     = LPC_REG_ADDR_MAX,
    parameter int unsigned STARVE_LIMIT = LPC_STARVE_LIMIT,
    parameter logic [7:0]  OOR_RDATA    = LPC_OOR_RDATA
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       HostReq,
    input  logic       HostWr,
    input  logic [7:0] HostAddr,
    input  logic [7:0] HostWrData,
    output logic       HostAck,
    output logic [7:0] HostRdData,
    input  logic       AuxReq,
    input  logic       AuxWr,
    input  logic [7:0] AuxAddr,
    input  logic [7:0] AuxWrData,
    output logic       AuxAck,
    output logic [7:0] AuxRdData,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic       Rd,
    output logic [7:0] DataWrSW,
    input  logic [7:0] DataRd,
    output logic       Busy
);

    localparam logic [3:0] STARVE_LIM = STARVE_LIMIT[3:0];

    lpc_arb_state_t state_q, state_d;
    lpc_req_id_t    winner_q, winner_d;
    logic [3:0]     starve_cnt_q, starve_cnt_d;
    logic           wr_q, wr_d;
    logic           oor_q, oor_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           wr_strobe_q, wr_strobe_d;
    logic           rd_strobe_q, rd_strobe_d;
    logic           host_ack_q, host_ack_d;
    logic           aux_ack_q, aux_ack_d;
    logic [7:0]     host_rdata_q, host_rdata_d;
    logic [7:0]     aux_rdata_q, aux_rdata_d;
    logic           busy_q, busy_d;

    logic           any_req;
    logic           host_wins;
    logic [7:0]     read_value;

    assign any_req   = HostReq | AuxReq;
    // Host keeps priority until it has taken STARVE_LIMIT grants in a row over a waiting Aux.
    assign host_wins = HostReq & (~AuxReq | (starve_cnt_q != STARVE_LIM));

    assign read_value = oor_q ? OOR_RDATA : DataRd;

    // State register
    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = GRANT;
            GRANT:   state_d = ACCESS;
            ACCESS:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        winner_d     = winner_q;
        wr_d         = wr_q;
        oor_d        = oor_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_strobe_d  = 1'b0;
        rd_strobe_d  = 1'b0;
        host_ack_d   = 1'b0;
        aux_ack_d    = 1'b0;
        host_rdata_d = host_rdata_q;
        aux_rdata_d  = aux_rdata_q;
        busy_d       = (state_d != IDLE);
        starve_cnt_d = starve_cnt_q;

        if (!AuxReq) begin
            starve_cnt_d = 4'd0;
        end else if (state_q == IDLE) begin
            starve_cnt_d = host_wins ? sat_inc4(starve_cnt_q) : 4'd0;
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    winner_d = host_wins ? REQ_HOST : REQ_AUX;
                    wr_d     = host_wins ? HostWr     : AuxWr;
                    addr_d   = host_wins ? HostAddr   : AuxAddr;
                    wdata_d  = host_wins ? HostWrData : AuxWrData;
                    oor_d    = (host_wins ? HostAddr : AuxAddr) > ADDR_MAX;
                end
            end
            GRANT: begin
                // Out-of-range accesses never reach the register file.
                wr_strobe_d = wr_q & ~oor_q;
                rd_strobe_d = ~wr_q & ~oor_q;
            end
            ACCESS: begin
                // DataRd is sampled here, before the read side effect lands.
                if (winner_q == REQ_HOST) begin
                    host_ack_d = 1'b1;
                    if (!wr_q) host_rdata_d = read_value;
                end else begin
                    aux_ack_d = 1'b1;
                    if (!wr_q) aux_rdata_d = read_value;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            winner_q     <= REQ_HOST;
            starve_cnt_q <= 4'd0;
            wr_q         <= 1'b0;
            oor_q        <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            wr_strobe_q  <= 1'b0;
            rd_strobe_q  <= 1'b0;
            host_ack_q   <= 1'b0;
            aux_ack_q    <= 1'b0;
            host_rdata_q <= 8'h00;
            aux_rdata_q  <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            winner_q     <= winner_d;
            starve_cnt_q <= starve_cnt_d;
            wr_q         <= wr_d;
            oor_q        <= oor_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_strobe_q  <= wr_strobe_d;
            rd_strobe_q  <= rd_strobe_d;
            host_ack_q   <= host_ack_d;
            aux_ack_q    <= aux_ack_d;
            host_rdata_q <= host_rdata_d;
            aux_rdata_q  <= aux_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign HostAck    = host_ack_q;
    assign HostRdData = host_rdata_q;
    assign AuxAck     = aux_ack_q;
    assign AuxRdData  = aux_rdata_q;
    assign Addr       = addr_q;
    assign Wr         = wr_strobe_q;
    assign Rd         = rd_strobe_q;
    assign DataWrSW   = wdata_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_lpc_reg_arbiter.sv
// Directed bench for lpc_reg_arbiter: vector table plus hand-written sequences
// for starvation, reset abort and a request held past its Ack.
module tb_lpc_reg_arbiter;

    logic       LpcClock = 1'b0;
    logic       PciReset;
    logic       HostReq, HostWr, AuxReq, AuxWr;
    logic [7:0] HostAddr, HostWrData, AuxAddr, AuxWrData;
    logic       HostAck, AuxAck, Wr, Rd, Busy;
    logic [7:0] HostRdData, AuxRdData, Addr, DataWrSW, DataRd;

    lpc_reg_arbiter dut (
        .LpcClock  (LpcClock),
        .PciReset  (PciReset),
        .HostReq   (HostReq),
        .HostWr    (HostWr),
        .HostAddr  (HostAddr),
        .HostWrData(HostWrData),
        .HostAck   (HostAck),
        .HostRdData(HostRdData),
        .AuxReq    (AuxReq),
        .AuxWr     (AuxWr),
        .AuxAddr   (AuxAddr),
        .AuxWrData (AuxWrData),
        .AuxAck    (AuxAck),
        .AuxRdData (AuxRdData),
        .Addr      (Addr),
        .Wr        (Wr),
        .Rd        (Rd),
        .DataWrSW  (DataWrSW),
        .DataRd    (DataRd),
        .Busy      (Busy)
    );

    always #15 LpcClock = ~LpcClock;

    // Register file model: 0x0B is read-clear.
    logic [7:0] regfile [0:31];
    logic       load_en = 1'b0;
    logic [4:0] load_addr = 5'd0;
    logic [7:0] load_data = 8'h00;

    always @(posedge LpcClock) begin
        if (load_en) begin
            regfile[load_addr] <= load_data;
        end else begin
            if (Wr && Addr <= 8'h1F) regfile[Addr[4:0]] <= DataWrSW;
            if (Rd && Addr == 8'h0B) regfile[5'h0B] <= 8'h00;
        end
    end

    always_comb begin
        DataRd = 8'h00;
        if (Addr <= 8'h1F) DataRd = regfile[Addr[4:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(posedge LpcClock);
        #1 load_en = 1'b0;
        @(negedge LpcClock);
    endtask

    // Watch one transaction for 8 samples; caller has just raised Req at a negedge.
    task automatic observe(input bit aux,
                           output int wr_cnt, output int rd_cnt, output int strobe_at,
                           output int ack_at, output int other_ack, output logic [3:0] busy_mask,
                           output logic [7:0] s_addr, output logic [7:0] s_wdata,
                           output logic [7:0] rdata);
        wr_cnt = 0; rd_cnt = 0; strobe_at = 0; ack_at = 0; other_ack = 0;
        busy_mask = 4'h0; s_addr = 8'h00; s_wdata = 8'h00; rdata = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge LpcClock);
            if (c <= 4) busy_mask[c-1] = Busy;
            if (Wr) begin wr_cnt++; strobe_at = c; s_addr = Addr; s_wdata = DataWrSW; end
            if (Rd) begin rd_cnt++; strobe_at = c; s_addr = Addr; end
            if ((aux ? AuxAck : HostAck) && ack_at == 0) begin
                ack_at = c;
                rdata  = aux ? AuxRdData : HostRdData;
                if (aux) AuxReq = 1'b0; else HostReq = 1'b0;
            end
            if (aux ? HostAck : AuxAck) other_ack++;
        end
    endtask

    typedef struct {
        bit         aux;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         exp_wr;
        int         exp_rd;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    int         wr_cnt, rd_cnt, strobe_at, ack_at, other_ack;
    logic [3:0] busy_mask;
    logic [7:0] s_addr, s_wdata, rdata;
    logic [7:0] last_host_rd, last_aux_rd;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'h0E, 8'h15, 1, 0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'h0B, 8'h00, 0, 1, 8'hC3};
        vecs[2] = '{1'b1, 1'b0, 8'h40, 8'h00, 0, 0, 8'hFF};
        vecs[3] = '{1'b1, 1'b1, 8'h40, 8'h77, 0, 0, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 8'h05, 8'hA5, 1, 0, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 8'h0E, 8'h00, 0, 1, 8'h15};
        vecs[6] = '{1'b1, 1'b0, 8'h05, 8'h00, 0, 1, 8'hA5};
        vecs[7] = '{1'b0, 1'b0, 8'h1F, 8'h00, 0, 1, 8'h3C};
        vecs[8] = '{1'b0, 1'b0, 8'h20, 8'h00, 0, 0, 8'hFF};

        PciReset = 1'b1;
        HostReq = 1'b0; HostWr = 1'b0; HostAddr = 8'h00; HostWrData = 8'h00;
        AuxReq  = 1'b0; AuxWr  = 1'b0; AuxAddr  = 8'h00; AuxWrData  = 8'h00;
        last_host_rd = 8'h00;
        last_aux_rd  = 8'h00;

        repeat (2) @(negedge LpcClock);
        check("reset_acks_strobes_busy", {28'd0, HostAck, AuxAck, Wr, Rd} | {31'd0, Busy}, 32'd0);
        check("reset_data_outputs", {HostRdData, AuxRdData, Addr, DataWrSW}, 32'd0);
        PciReset = 1'b0;
        @(negedge LpcClock);
        preload(5'h0B, 8'hC3);
        preload(5'h1F, 8'h3C);

        // Table-driven single transactions
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].aux) begin
                AuxWr = vecs[i].wr; AuxAddr = vecs[i].addr; AuxWrData = vecs[i].wdata; AuxReq = 1'b1;
            end else begin
                HostWr = vecs[i].wr; HostAddr = vecs[i].addr; HostWrData = vecs[i].wdata; HostReq = 1'b1;
            end
            observe(vecs[i].aux, wr_cnt, rd_cnt, strobe_at, ack_at, other_ack, busy_mask,
                    s_addr, s_wdata, rdata);
            $display("vec %0d: %s %s addr=0x%02h wdata=0x%02h -> wr=%0d rd=%0d ack@%0d rdata=0x%02h",
                     i, vecs[i].aux ? "aux " : "host", vecs[i].wr ? "wr" : "rd",
                     vecs[i].addr, vecs[i].wdata, wr_cnt, rd_cnt, ack_at, rdata);
            check($sformatf("v%0d_wr_pulses", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_rd_pulses", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_ack_cycle", i), 32'(ack_at), 32'd3);
            check($sformatf("v%0d_other_ack", i), 32'(other_ack), 32'd0);
            check($sformatf("v%0d_busy", i), 32'(busy_mask), 32'h7);
            if (vecs[i].exp_wr + vecs[i].exp_rd > 0) begin
                check($sformatf("v%0d_strobe_cycle", i), 32'(strobe_at), 32'd2);
                check($sformatf("v%0d_strobe_addr", i), 32'(s_addr), 32'(vecs[i].addr));
            end
            if (vecs[i].exp_wr > 0)
                check($sformatf("v%0d_strobe_wdata", i), 32'(s_wdata), 32'(vecs[i].wdata));
            if (!vecs[i].wr) begin
                check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
                if (vecs[i].aux) last_aux_rd = vecs[i].exp_rdata;
                else             last_host_rd = vecs[i].exp_rdata;
            end
            check($sformatf("v%0d_host_rdata_held", i), 32'(HostRdData), 32'(last_host_rd));
            check($sformatf("v%0d_aux_rdata_held", i), 32'(AuxRdData), 32'(last_aux_rd));
        end

        // Both requesters held continuously: expect H,H,H,H,A,H,H,H,H,A
        begin
            int   n_acks = 0;
            int   both = 0;
            bit   order [10];
            logic [7:0] ack_data [10];
            HostWr = 1'b0; HostAddr = 8'h0E; AuxWr = 1'b0; AuxAddr = 8'h05;
            HostReq = 1'b1; AuxReq = 1'b1;
            for (int c = 0; c < 60 && n_acks < 10; c++) begin
                @(negedge LpcClock);
                if (HostAck && AuxAck) both++;
                if (HostAck || AuxAck) begin
                    order[n_acks]    = AuxAck;
                    ack_data[n_acks] = AuxAck ? AuxRdData : HostRdData;
                    n_acks++;
                    if (n_acks == 10) begin HostReq = 1'b0; AuxReq = 1'b0; end
                end
            end
            HostReq = 1'b0; AuxReq = 1'b0;
            $display("starve: %0d acks, order %s", n_acks, $sformatf("%b", {order[0], order[1],
                     order[2], order[3], order[4], order[5], order[6], order[7], order[8], order[9]}));
            check("starve_ack_count", 32'(n_acks), 32'd10);
            check("starve_dual_ack", 32'(both), 32'd0);
            for (int k = 0; k < n_acks; k++) begin
                check($sformatf("starve_grant_%0d", k), 32'(order[k]), (k % 5 == 4) ? 32'd1 : 32'd0);
                check($sformatf("starve_rdata_%0d", k), 32'(ack_data[k]),
                      (k % 5 == 4) ? 32'hA5 : 32'h15);
            end
            repeat (4) @(negedge LpcClock);
            last_host_rd = 8'h15;
        end

        // Reset asserted during ACCESS aborts the transaction; held HostReq is serviced afresh
        begin
            int acks_in_reset = 0;
            HostWr = 1'b0; HostAddr = 8'h0E; HostReq = 1'b1;
            repeat (2) @(negedge LpcClock);
            check("rst_rd_in_access", 32'(Rd), 32'd1);
            PciReset = 1'b1;
            #1;
            check("rst_strobes_acks_busy", {28'd0, HostAck, AuxAck, Wr, Rd} | {31'd0, Busy}, 32'd0);
            check("rst_data_outputs", {HostRdData, AuxRdData, Addr, DataWrSW}, 32'd0);
            for (int c = 0; c < 2; c++) begin
                @(negedge LpcClock);
                if (HostAck || AuxAck) acks_in_reset++;
            end
            check("rst_no_ack", 32'(acks_in_reset), 32'd0);
            PciReset = 1'b0;
            observe(1'b0, wr_cnt, rd_cnt, strobe_at, ack_at, other_ack, busy_mask,
                    s_addr, s_wdata, rdata);
            $display("reset-retry: host rd 0x0E -> rd=%0d ack@%0d rdata=0x%02h", rd_cnt, ack_at, rdata);
            check("rst_retry_rd_pulses", 32'(rd_cnt), 32'd1);
            check("rst_retry_ack_cycle", 32'(ack_at), 32'd3);
            check("rst_retry_rdata", 32'(rdata), 32'h15);
        end

        // HostReq held one cycle past Ack on read-clear 0x0B: two reads, C3 then 00
        begin
            int   rd_0b = 0;
            int   n_acks = 0;
            int   ack_cyc [2];
            logic [7:0] ack_data [2];
            preload(5'h0B, 8'hC3);
            HostWr = 1'b0; HostAddr = 8'h0B; HostReq = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                @(negedge LpcClock);
                if (Rd && Addr == 8'h0B) rd_0b++;
                if (HostAck && n_acks < 2) begin
                    ack_cyc[n_acks]  = c;
                    ack_data[n_acks] = HostRdData;
                    n_acks++;
                end
                if (c == 5) HostReq = 1'b0;
            end
            $display("held-req: %0d Rd pulses on 0x0B, %0d acks", rd_0b, n_acks);
            check("hold_rd_pulses", 32'(rd_0b), 32'd2);
            check("hold_ack_count", 32'(n_acks), 32'd2);
            if (n_acks == 2) begin
                check("hold_ack1_cycle", 32'(ack_cyc[0]), 32'd3);
                check("hold_ack2_cycle", 32'(ack_cyc[1]), 32'd7);
                check("hold_rdata1", 32'(ack_data[0]), 32'hC3);
                check("hold_rdata2", 32'(ack_data[1]), 32'h00);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
